// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a load/busy handshake.
// Sends pin[N-1] first and pin[0] last on sln_out_o, then pulses done_o for one cycle.
module piso_serializer #(
   parameter int unsigned N = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [0:N-1] pin_i,
   input  logic         hold_i,
   output logic         sln_out_o,
   output logic         valid_o,
   output logic         busy_o,
   output logic         ready_o,
   output logic         done_o
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e          state_q, state_d;
   logic [0:N-1]    sreg_q, sreg_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_i) begin
               sreg_d  = pin_i;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (!hold_i) begin
               sreg_d = {1'b0, sreg_q[0:N-2]};
               // Last bit leaves this cycle; park the counter instead of wrapping.
               if (cnt_q == CntLast) begin
                  cnt_d   = '0;
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign busy_o    = (state_q == StShift);
   assign ready_o   = ~busy_o;
   assign valid_o   = busy_o & ~hold_i;
   assign sln_out_o = busy_o & sreg_q[N-1];
   assign done_o    = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus queues expected bits/words,
// a negedge monitor with a paired receiver pops and compares.
module tb_piso_serializer;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic         hold;
   logic [0:N-1] pin;
   logic         sln, valid, busy, ready, done;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;

   bit           exp_bits[$];
   logic [0:N-1] exp_words[$];
   logic [0:N-1] rx_q;
   int           rx_cnt = 0;

   always #5 clk = ~clk;

   piso_serializer #(.N(N)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (load),
      .pin_i    (pin),
      .hold_i   (hold),
      .sln_out_o(sln),
      .valid_o  (valid),
      .busy_o   (busy),
      .ready_o  (ready),
      .done_o   (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word is given as it appears on pin[0:7]; literal bit k leaves k-th.
   task automatic send(input logic [7:0] w);
      pin  = w;
      load = 1'b1;
      for (int k = 0; k < N; k++) exp_bits.push_back(w[k]);
      exp_words.push_back(w);
   endtask

   task automatic wait_done(output time t);
      t = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin
            t = $time;
            return;
         end
         tick();
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: pop expected bit per valid cycle, compare received word every N bits.
   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (valid === 1'b1) begin
               if (exp_bits.size() == 0) check("unexpected_bit", 32'd1, 32'd0);
               else check("serial_bit", {31'd0, sln}, {31'd0, exp_bits.pop_front()});
               rx_q = {sln, rx_q[0:N-2]};
               rx_cnt++;
               if (rx_cnt == N) begin
                  rx_cnt = 0;
                  if (exp_words.size() == 0) check("unexpected_word", 32'd1, 32'd0);
                  else check("rx_word", {24'd0, rx_q}, {24'd0, exp_words.pop_front()});
               end
            end
            if (done === 1'b1) begin
               done_seen++;
               check("done_after_full_word", rx_cnt, 32'd0);
            end
         end
      end
   end

   initial begin
      time t0, t1;
      logic s_frozen;
      int dn;

      rst  = 1'b1;
      load = 1'b1;
      hold = 1'b0;
      pin  = 8'hFF;

      // Reset dominates load.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_ready", {31'd0, ready}, 32'd1);
         check("rst_sln", {31'd0, sln}, 32'd0);
         check("rst_done", {31'd0, done}, 32'd0);
      end
      rst  = 1'b0;
      load = 1'b0;
      tick();
      check("idle_valid", {31'd0, valid}, 32'd0);

      // Single word.
      t0 = $time;
      send(8'b1011_0010);
      tick();
      load = 1'b0;
      check("busy_after_load", {31'd0, busy}, 32'd1);
      check("ready_after_load", {31'd0, ready}, 32'd0);
      wait_done(t1);
      check("done_latency", 32'((t1 - t0) / 10), 32'd9);
      check("ready_at_done", {31'd0, ready}, 32'd1);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // Hold for two cycles mid-word.
      t0 = $time;
      send(8'b1011_0010);
      tick();
      load = 1'b0;
      tick();
      tick();
      tick();
      s_frozen = sln;
      hold = 1'b1;
      #1;
      check("hold_valid_0", {31'd0, valid}, 32'd0);
      tick();
      check("hold_valid_1", {31'd0, valid}, 32'd0);
      check("hold_sln_frozen", {31'd0, sln}, {31'd0, s_frozen});
      check("hold_busy", {31'd0, busy}, 32'd1);
      tick();
      hold = 1'b0;
      #1;
      check("hold_release_sln", {31'd0, sln}, {31'd0, s_frozen});
      check("hold_release_valid", {31'd0, valid}, 32'd1);
      wait_done(t1);
      check("hold_done_latency", 32'((t1 - t0) / 10), 32'd11);
      tick();

      // Load while busy is ignored.
      send(8'hA5);
      tick();
      load = 1'b0;
      tick();
      tick();
      tick();
      pin  = 8'h3C;
      load = 1'b1;
      tick();
      load = 1'b0;
      pin  = 8'h00;
      wait_done(t1);
      tick();
      check("no_queued_load", {31'd0, busy}, 32'd0);
      tick();
      check("still_idle", {31'd0, busy}, 32'd0);

      // Back-to-back with load held high.
      send(8'hF0);
      tick();
      pin = 8'h0F;
      for (int k = 0; k < N; k++) exp_bits.push_back(pin[N-1-k]);
      exp_words.push_back(8'h0F);
      wait_done(t0);
      check("b2b_load_still_high", {31'd0, load}, 32'd1);
      tick();
      load = 1'b0;
      check("b2b_second_busy", {31'd0, busy}, 32'd1);
      wait_done(t1);
      check("b2b_done_spacing", 32'((t1 - t0) / 10), 32'd9);
      tick();

      // Reset mid-word aborts without done.
      dn = done_seen;
      send(8'hFF);
      tick();
      load = 1'b0;
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_sln", {31'd0, sln}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      exp_bits.delete();
      exp_words.delete();
      rx_cnt = 0;
      for (int i = 0; i < 3; i++) tick();
      check("abort_no_done", done_seen, dn);
      send(8'h81);
      tick();
      load = 1'b0;
      wait_done(t1);
      tick();

      check("done_pulse_count", done_seen, 32'd6);
      check("bits_drained", exp_bits.size(), 32'd0);
      check("words_drained", exp_words.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register with a load/busy handshake: the transmit end of the team's serial-in shift register links. It captures an N-bit word on a load request, drives it out one bit per clock on `sln_out`, and pulses `done` when the word has gone. A serial-in shift register receiver sampling `sln_out` on the same `clk` while `valid` is high holds the original word, index-for-index, after N shifts.

## Interface
- `N`, default 8: word width in bits. Legal for N >= 2.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset. Sampled only on rising `clk`.
- `load` in 1: request to capture `pin`. Honoured only in IDLE.
- `pin` in [0:N-1]: parallel word to transmit.
- `hold` in 1: stall. While high in SHIFT, the shift register, the counter and `sln_out` are frozen.
- `sln_out` out 1: serial data. `sreg[N-1]` in SHIFT, 0 otherwise.
- `valid` out 1: high when `sln_out` carries a data bit the receiver must shift in (SHIFT and not `hold`).
- `busy` out 1: high in SHIFT.
- `ready` out 1: high in IDLE (equal to ~busy).
- `done` out 1: one-cycle pulse after the last bit.

## Operation
- Registers: `sreg` [0:N-1], bit counter `cnt` ($clog2(N) bits), state {IDLE, SHIFT}, `done` flop.
- Bit order: `pin[N-1]` goes out first and `pin[0]` goes out last. This matches a receiver that computes q <= {sln, q[0:N-2]}.
- IDLE:
  - If `load` is high: `sreg <= pin`, `cnt <= 0`, state goes to SHIFT.
  - Otherwise the registers hold.
- SHIFT with `hold` low:
  - `sreg <= {1'b0, sreg[0:N-2]}` (shifts toward higher index).
  - `cnt <= cnt + 1`.
  - When `cnt == N-1`: go to IDLE and set `done <= 1`. The counter never wraps past N-1.
- SHIFT with `hold` high: all state holds, and `valid` is low for that cycle.
- `done` is high for exactly one cycle, the first IDLE cycle after the transfer. It clears on the next edge unless a new transfer completes.
- `load` behaviour:
  - While busy, `load` is ignored. The current word is not corrupted, and no request is queued.
  - `load` high in the same cycle that `done` is high (IDLE) is accepted, giving back-to-back words with a one-cycle gap.
- Reset:
  - `rst` wins over every other input.
  - Next edge: state IDLE, `sreg` = 0, `cnt` = 0, `done` = 0.
  - A reset mid-word aborts the transfer and does not produce a `done` pulse.

## Timing
- Reset values: `sln_out`=0, `valid`=0, `busy`=0, `ready`=1, `done`=0.
- Let the load be accepted at edge E0. `pin[N-1-k]` is on `sln_out` with `valid` high in the cycle after edge E0+k, for k = 0..N-1. This assumes no `hold`.
- Each `hold` cycle delays the remaining bits by one cycle.
- `busy` rises at E0 and falls at E0+N (plus the number of hold cycles). `done` is high in the cycle following that edge.
- Minimum word period, load to next load accepted: N+1 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `load`/`pin` to `sln_out`. `valid` has a combinational path from `hold` only.

## Test plan
- Reset: hold `rst`=1 for 3 edges while `load`=1 and `pin`=8'hFF. Required: `busy`=0, `ready`=1, `sln_out`=0, `done`=0 throughout.
- Single word, N=8, `pin`=8'b1011_0010 ([0:7]), `load` for 1 cycle. Required: `sln_out` sequence 0,1,0,0,1,1,0,1 on 8 consecutive `valid` cycles. `done` pulses once, 9 cycles after load. A paired receiver's q equals 8'b1011_0010.
- Hold: same word with `hold`=1 for 2 cycles after bit 3. Required: `sln_out` frozen and `valid`=0 for those 2 cycles. `done` is delayed by exactly 2 cycles. Received word is unchanged.
- Load while busy: `pin`=8'hA5 loaded, then `load` with `pin`=8'h3C at bit 4. Required: 8'hA5 is transmitted intact and 8'h3C is never sent.
- Back-to-back: `load` held high continuously with `pin`=8'hF0 then 8'h0F. Required: two words 9 cycles apart, two `done` pulses, and the receiver captures both.
- Mid-word reset: `rst` at bit 5 of 8'hFF. Required: IDLE on the next edge, `sln_out`=0, no `done`. A following load of 8'h81 transmits correctly.
